turbo_sched: RTL and testbench



---
 rtl/turbo_sched.sv | 122 ++++++++++++
 tb/tb_turbo_sched.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/turbo_sched.sv
// turbo_sched: CPU clock-enable strobe from clk28 at 3.5/7/14 MHz with phase-aligned speed changes.
// Optional macro TURBO_SCHED_SLOW_IO_EN enables the 3.5 MHz slowdown of slow-port I/O cycles.
module turbo_sched #(
  parameter int PEND_TIMEOUT = 1023,
  parameter int TO_W         = 10
) (
  input  logic        clk28,
  input  logic        rst_n,
  input  logic        bus_mreq,
  input  logic        bus_ioreq,
  input  logic [15:0] bus_a,
  input  logic [1:0]  turbo_req,
  output logic        cpu_tick,
  output logic [1:0]  speed,
  output logic        switching
);
  // state   | meaning
  // RUN     | ticking at the committed speed
  // PEND    | speed change waiting for cnt==7 with an idle bus, or the timeout
  // SLOW_IO | slow-port I/O cycle held at 3.5 MHz
  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] PEND    = 2'd1;
  localparam logic [1:0] SLOW_IO = 2'd2;

  localparam logic [1:0] TURBO_NONE = 2'd0;
  localparam logic [1:0] TURBO_7    = 2'd1;
  localparam logic [1:0] TURBO_14   = 2'd2;

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(PEND_TIMEOUT);

  logic [2:0]      cnt_q, cnt_d;
  logic [1:0]      state_q, state_d;
  logic [1:0]      cur_q, cur_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            cpu_tick_q, cpu_tick_d;
  logic [1:0]      speed_q, speed_d;

  logic [1:0] req_norm;
  logic [1:0] eff;
  logic       match;
  logic       slow_io;
  logic       bus_idle;

`ifdef TURBO_SCHED_SLOW_IO_EN
  assign slow_io = bus_ioreq && (!bus_a[0] || (bus_a[15] && !bus_a[1]));
`else
  logic unused_bus_a;
  assign unused_bus_a = ^bus_a;
  assign slow_io      = 1'b0;
`endif

  assign bus_idle = !bus_mreq && !bus_ioreq;

  always_comb begin
    req_norm = TURBO_NONE;
    if (turbo_req == TURBO_7 || turbo_req == TURBO_14) req_norm = turbo_req;

    eff = (state_q == SLOW_IO) ? TURBO_NONE : cur_q;

    match = 1'b0;
    case (eff)
      TURBO_7:  match = (cnt_q[1:0] == 2'd3);
      TURBO_14: match = cnt_q[0];
      default:  match = (cnt_q == 3'd7);
    endcase

    cnt_d      = cnt_q + 3'd1;
    cpu_tick_d = match;
    speed_d    = eff;
    state_d    = state_q;
    cur_d      = cur_q;
    to_cnt_d   = to_cnt_q;

    case (state_q)
      RUN: begin
        if (req_norm != cur_q) begin
          state_d  = PEND;
          to_cnt_d = '0;
        end else if (cur_q != TURBO_NONE && slow_io) begin
          state_d = SLOW_IO;
        end
      end
      PEND: begin
        if (to_cnt_q != TO_MAX) to_cnt_d = to_cnt_q + TO_W'(1);
        // cnt==7 is a tick point at every speed, so switching here never shortens a tick
        if (req_norm == cur_q) begin
          state_d = RUN;
        end else if (cnt_q == 3'd7 && (bus_idle || to_cnt_q == TO_MAX)) begin
          cur_d   = req_norm;
          state_d = RUN;
        end
      end
      SLOW_IO: begin
        if (!bus_ioreq && cnt_q == 3'd7) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= 3'd0;
      state_q    <= RUN;
      cur_q      <= TURBO_NONE;
      to_cnt_q   <= '0;
      cpu_tick_q <= 1'b0;
      speed_q    <= TURBO_NONE;
    end else begin
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      cur_q      <= cur_d;
      to_cnt_q   <= to_cnt_d;
      cpu_tick_q <= cpu_tick_d;
      speed_q    <= speed_d;
    end
  end

  assign cpu_tick  = cpu_tick_q;
  assign speed     = speed_q;
  assign switching = (state_q == PEND);

endmodule

// File: tb/tb_turbo_sched.sv
// Scoreboard bench for turbo_sched: a per-cycle reference model queues expected outputs,
// a monitor on the falling edge pops and compares them against the DUT.
module tb_turbo_sched;
  localparam int PEND_TIMEOUT = 1023;

  logic        clk28 = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_mreq = 1'b0;
  logic        bus_ioreq = 1'b0;
  logic [15:0] bus_a = 16'h0000;
  logic [1:0]  turbo_req = 2'd0;
  logic        cpu_tick;
  logic [1:0]  speed;
  logic        switching;

  turbo_sched dut (
    .clk28     (clk28),
    .rst_n     (rst_n),
    .bus_mreq  (bus_mreq),
    .bus_ioreq (bus_ioreq),
    .bus_a     (bus_a),
    .turbo_req (turbo_req),
    .cpu_tick  (cpu_tick),
    .speed     (speed),
    .switching (switching)
  );

  always #5 clk28 = ~clk28;

  typedef struct {
    logic       tick;
    logic [1:0] spd;
    logic       sw;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model: speeds as 0 (3.5 MHz), 1 (7 MHz), 2 (14 MHz)
  int m_phase;
  int m_speed;
  bit m_slow;
  bit m_pend;
  int m_age;

  function automatic int norm_req(input logic [1:0] r);
    if (r == 2'd1) return 1;
    if (r == 2'd2) return 2;
    return 0;
  endfunction

  function automatic int period_of(input int s);
    if (s == 2) return 2;
    if (s == 1) return 4;
    return 8;
  endfunction

  function automatic bit slow_port(input logic io, input logic [15:0] a);
    int addr;
    bit hit;
    addr = int'(a);
    hit  = io && ((addr % 2 == 0) || (addr >= 32768 && ((addr / 2) % 2 == 0)));
`ifndef TURBO_SCHED_SLOW_IO_EN
    hit = 1'b0;
`endif
    return hit;
  endfunction

  task automatic compare(input string name, input logic [1:0] got, input logic [1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, got, want, $time);
    end
  endtask

  always @(posedge clk28 or negedge rst_n) begin : model
    int   eff;
    int   p;
    int   req;
    exp_t e;
    if (!rst_n) begin
      m_phase = 0;
      m_speed = 0;
      m_slow  = 1'b0;
      m_pend  = 1'b0;
      m_age   = 0;
      exp_q.delete();
      e.tick = 1'b0;
      e.spd  = 2'd0;
      e.sw   = 1'b0;
      exp_q.push_back(e);
    end else begin
      eff    = m_slow ? 0 : m_speed;
      p      = period_of(eff);
      e.tick = ((m_phase % p) == p - 1);
      e.spd  = 2'(eff);
      req    = norm_req(turbo_req);
      if (m_pend) begin
        if (req == m_speed) begin
          m_pend = 1'b0;
        end else if (m_phase == 7 && ((!bus_mreq && !bus_ioreq) || m_age >= PEND_TIMEOUT)) begin
          m_speed = req;
          m_pend  = 1'b0;
        end
        if (m_age < PEND_TIMEOUT) m_age++;
      end else if (m_slow) begin
        if (!bus_ioreq && m_phase == 7) m_slow = 1'b0;
      end else if (req != m_speed) begin
        m_pend = 1'b1;
        m_age  = 0;
      end else if (m_speed != 0 && slow_port(bus_ioreq, bus_a)) begin
        m_slow = 1'b1;
      end
      m_phase = (m_phase + 1) % 8;
      e.sw    = m_pend;
      exp_q.push_back(e);
    end
  end

  always @(negedge clk28) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compare("cpu_tick", {1'b0, cpu_tick}, {1'b0, e.tick});
      compare("speed", speed, e.spd);
      compare("switching", {1'b0, switching}, {1'b0, e.sw});
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk28);
      #2;
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    compare("rst_cpu_tick", {1'b0, cpu_tick}, 2'd0);
    compare("rst_speed", speed, 2'd0);
    compare("rst_switching", {1'b0, switching}, 2'd0);
    @(posedge clk28);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic set_bus(input logic mreq, input logic ioreq, input logic [15:0] a);
    bus_mreq  = mreq;
    bus_ioreq = ioreq;
    bus_a     = a;
  endtask

  logic [15:0] addr_tab[6] = '{16'h00FE, 16'hFFFD, 16'hBFFD, 16'h7FFD, 16'h1235, 16'h00FF};

  initial begin
    cycles(3);
    rst_n = 1'b1;

    // 3.5 MHz idle ticking
    cycles(40);

    // idle bus, switch to 14 MHz at the next phase-aligned point
    turbo_req = 2'd2;
    cycles(40);

    // busy memory bus forces the switch only after the pending timeout
    set_bus(1'b1, 1'b0, 16'h0000);
    turbo_req = 2'd1;
    cycles(1100);
    set_bus(1'b0, 1'b0, 16'h0000);
    cycles(20);

    // slow-port I/O at 14 MHz: ULA then AY
    turbo_req = 2'd2;
    cycles(30);
    set_bus(1'b0, 1'b1, 16'h00FE);
    cycles(40);
    set_bus(1'b0, 1'b0, 16'h0000);
    cycles(30);
    set_bus(1'b0, 1'b1, 16'hBFFD);
    cycles(25);
    set_bus(1'b0, 1'b0, 16'h0000);
    cycles(20);

    // request change while a slow I/O cycle is in progress
    set_bus(1'b0, 1'b1, 16'hFFFD);
    cycles(3);
    turbo_req = 2'd1;
    cycles(12);
    set_bus(1'b0, 1'b0, 16'h0000);
    cycles(30);

    // request that reverts while the bus is busy
    turbo_req = 2'd0;
    cycles(30);
    set_bus(1'b1, 1'b0, 16'h0000);
    turbo_req = 2'd2;
    cycles(5);
    turbo_req = 2'd0;
    cycles(40);

    // reset in the middle of a pending change
    turbo_req = 2'd2;
    cycles(5);
    pulse_reset();
    turbo_req = 2'd0;
    set_bus(1'b0, 1'b0, 16'h0000);
    cycles(40);

    // randomized segments
    for (int seg = 0; seg < 160; seg++) begin
      int sel;
      if ($urandom_range(0, 3) == 0) turbo_req = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 6);
      set_bus($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
              (sel == 6) ? 16'($urandom) : addr_tab[sel]);
      if ($urandom_range(0, 49) == 0) pulse_reset();
      cycles($urandom_range(1, 25));
    end

    set_bus(1'b0, 1'b0, 16'h0000);
    cycles(10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
